// File: rtl/gate_arb_pkg.sv
// ---------------------------------------------------------------
// gate_arb_pkg : opcode constants and FSM state type for gate arbiter
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package gate_arb_pkg;

  localparam logic [1:0] OP_NAND = 2'b00;
  localparam logic [1:0] OP_NOR  = 2'b01;
  localparam logic [1:0] OP_NOT  = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/gate_unit.sv
// ---------------------------------------------------------------
// gate_unit : combinational NAND / NOR / NOT datapath with illegal-op flag
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module gate_unit
  import gate_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_NOT:  y = ~a;
      default: err = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/gate_unit_arbiter.sv
// ---------------------------------------------------------------
// gate_unit_arbiter : round-robin sharing of one gate_unit among N_REQ clients
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module gate_unit_arbiter
  import gate_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_err
);

  // Scan offsets from the top down so the smallest offset from ptr wins.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] w;
    int              idx;
    w = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (r[idx]) w = ID_W'(idx);
    end
    return w;
  endfunction

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  cur_id;
  logic [1:0]       cur_op;
  logic [WIDTH-1:0] cur_a;
  logic [WIDTH-1:0] cur_b;
  logic [ID_W-1:0]  win;
  logic [WIDTH-1:0] gu_y;
  logic             gu_err;

  assign win = rr_pick(req, rr_ptr);

  gate_unit #(.WIDTH(WIDTH)) u_gate (
    .op  (cur_op),
    .a   (cur_a),
    .b   (cur_b),
    .y   (gu_y),
    .err (gu_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      cur_op    <= '0;
      cur_a     <= '0;
      cur_b     <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            cur_op <= op[2*win +: 2];
            cur_a  <= a_in[win*WIDTH +: WIDTH];
            cur_b  <= b_in[win*WIDTH +: WIDTH];
            cur_id <= win;
            gnt    <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= gu_y;
          rsp_err   <= gu_err;
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            rr_ptr    <= (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_unit_arbiter.sv
// ---------------------------------------------------------------
// tb_gate_unit_arbiter : directed + random checks against a reference model
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_gate_unit_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [2*N-1:0] op;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int m_ptr    = 0;

  gate_unit_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: first requester at or after ptr, wrapping.
  function automatic int model_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] gate_ref(input logic [1:0] o, input logic [W-1:0] a,
                                            input logic [W-1:0] b, output bit e);
    e = 1'b0;
    case (o)
      2'b00:   return ~(a & b);
      2'b01:   return ~(a | b);
      2'b10:   return ~a;
      default: begin e = 1'b1; return '0; end
    endcase
  endfunction

  task automatic set_req_ops(input int i, input logic [1:0] o, input logic [W-1:0] a,
                             input logic [W-1:0] b);
    op[2*i +: 2] = o;
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic scramble_operands;
    for (int i = 0; i < N; i++) begin
      a_in[i*W +: W] = W'($urandom);
      b_in[i*W +: W] = W'($urandom);
      op[2*i +: 2]   = 2'($urandom);
    end
  endtask

  // One full transaction from the current IDLE state, checked cycle by cycle.
  task automatic run_txn(input int stall, input bit drop, input bit scramble,
                         input logic [N-1:0] add_req, output int got_id, output int gcyc);
    int           w;
    logic [W-1:0] ed;
    bit           ee;
    w = model_pick(req, m_ptr);
    if (w < 0) w = 0;
    ed = gate_ref(op[2*w +: 2], a_in[w*W +: W], b_in[w*W +: W], ee);
    tick;
    chk("gnt", gnt, 32'd1 << w);
    chk("busy_exec", busy, 1);
    chk("valid_exec", rsp_valid, 0);
    gcyc = cyc;
    if (drop) req[w] = 1'b0;
    req = req | add_req;
    if (scramble) scramble_operands();
    rsp_ready = (stall == 0);
    tick;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_id", rsp_id, w);
    chk("rsp_err", rsp_err, ee);
    chk("gnt_resp", gnt, 0);
    got_id = rsp_id;
    for (int i = 0; i < stall; i++) begin
      tick;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, ed);
      chk("hold_id", rsp_id, w);
      chk("hold_gnt", gnt, 0);
    end
    rsp_ready = 1'b1;
    tick;
    chk("valid_done", rsp_valid, 0);
    chk("busy_done", busy, 0);
    m_ptr = (w + 1) % N;
  endtask

  initial begin
    int id;
    int gc;
    int gc_prev;
    rst_n = 1'b0; req = '0; op = '0; a_in = '0; b_in = '0; rsp_ready = 1'b0;
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", rsp_data, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    tick;
    chk("idle_gnt", gnt, 0);

    // Single request, NAND
    set_req_ops(0, 2'b00, 8'hF0, 8'hCC);
    req = 4'b0001;
    run_txn(0, 1, 0, '0, id, gc);
    chk("single_data_const", rsp_data, 8'h3F);

    // All opcodes on requester 3
    set_req_ops(3, 2'b01, 8'hA5, 8'h0F); req = 4'b1000;
    run_txn(0, 1, 0, '0, id, gc);
    chk("nor_const", rsp_data, 8'h50);
    set_req_ops(3, 2'b10, 8'hA5, 8'h0F); req = 4'b1000;
    run_txn(0, 1, 0, '0, id, gc);
    chk("not_const", rsp_data, 8'h5A);
    set_req_ops(3, 2'b11, 8'hA5, 8'h0F); req = 4'b1000;
    run_txn(0, 1, 0, '0, id, gc);
    chk("ill_data_const", rsp_data, 8'h00);
    chk("ill_err_const", rsp_err, 1);

    // Round-robin with all requesting continuously
    for (int i = 0; i < N; i++) set_req_ops(i, 2'($urandom_range(0, 2)), W'($urandom), W'($urandom));
    req = 4'b1111;
    gc_prev = 0;
    for (int i = 0; i < 5; i++) begin
      run_txn(0, 0, 0, '0, id, gc);
      chk("rr_order", id, i % N);
      if (i > 0) chk("rr_spacing", gc - gc_prev, 3);
      gc_prev = gc;
    end

    // Backpressure with new request and operand churn during RESP
    req = 4'b0001;
    run_txn(5, 1, 1, 4'b0010, id, gc);
    chk("bp_first", id, 0);
    run_txn(0, 1, 0, '0, id, gc);
    chk("bp_next", id, 1);

    // Wrap and skip
    req = 4'b1000;
    run_txn(0, 1, 0, '0, id, gc);
    req = 4'b0101;
    run_txn(0, 1, 0, '0, id, gc);
    chk("wrap_grant", id, 0);
    run_txn(0, 1, 0, '0, id, gc);
    chk("skip_grant", id, 2);

    // Reset in RESP: rr_ptr sits at 3 before reset
    set_req_ops(3, 2'b10, 8'h00, 8'h00);
    req = 4'b1000;
    tick;
    chk("pre_rst_gnt", gnt, 4'b1000);
    req = '0; rsp_ready = 1'b0;
    tick;
    chk("pre_rst_valid", rsp_valid, 1);
    chk("pre_rst_data", rsp_data, 8'hFF);
    rst_n = 1'b0;
    #1;
    chk("async_valid", rsp_valid, 0);
    chk("async_data", rsp_data, 0);
    chk("async_id", rsp_id, 0);
    chk("async_busy", busy, 0);
    chk("async_err", rsp_err, 0);
    chk("async_gnt", gnt, 0);
    m_ptr = 0;
    tick;
    rst_n = 1'b1; rsp_ready = 1'b1;
    tick;
    chk("post_rst_idle", rsp_valid, 0);
    req = 4'b1100;
    run_txn(0, 1, 0, '0, id, gc);
    chk("post_rst_grant", id, 2);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      scramble_operands();
      req = 4'($urandom_range(1, 15));
      run_txn(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), '0, id, gc);
      if ($urandom_range(0, 3) == 0) begin
        req = '0;
        tick;
        chk("idle_no_gnt", gnt, 0);
        chk("idle_not_busy", busy, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/gate_unit_arbiter.md
Name: gate_unit_arbiter

Overview:
- Shares one bitwise inverting-gate unit (NAND / NOR / NOT) among N_REQ requesters.
- Each requester presents an opcode and operands. The arbiter grants requesters round-robin, sequences the shared gate unit, and returns a registered result tagged with the requester ID.
- Sits between client logic and the combinational gate datapath. It is the only path by which clients use that datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.
- ID_W, $clog2(N_REQ), width of requester ID (derived, not overridable).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request, level; held until its gnt bit.
- op  in  2*N_REQ  per-requester opcode, slice i = op[2i+1:2i].
  - 00 = NAND, 01 = NOR, 10 = NOT a, 11 = illegal.
- a_in  in  N_REQ*WIDTH  per-requester operand A, slice i.
- b_in  in  N_REQ*WIDTH  per-requester operand B, slice i; ignored for NOT.
- gnt  out  N_REQ  one-hot, registered, high exactly one cycle when the request is accepted.
- busy  out  1  high in EXEC and RESP.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_W  requester index of the current result.
- rsp_data  out  WIDTH  gate result.
- rsp_err  out  1  illegal opcode flag, valid with rsp_valid.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; rr_ptr = 0.
  - gnt = 0, busy = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_err = 0.
  - Internal operand/op latches = 0.
  - Reset asserted mid-transaction aborts it silently; no response is produced.
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If req != 0, select winner w = first set bit of req searching from rr_ptr upward with wrap-around (rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ...).
  - On that edge: latch op/a/b of w and id = w, set gnt = one-hot(w), go EXEC.
  - If req == 0, stay in IDLE and keep gnt = 0.
- EXEC (one cycle):
  - gnt returns to 0.
  - Compute result from the latched values:
    - NAND = ~(a & b); NOR = ~(a | b); NOT = ~a.
    - Illegal opcode: result = 0 and err = 1.
  - On the edge: rsp_data, rsp_err and rsp_id are registered, rsp_valid = 1, go RESP.
- RESP:
  - Hold rsp_valid, rsp_data, rsp_id and rsp_err stable until rsp_ready = 1.
  - On the handshake edge: rsp_valid = 0, rr_ptr = (id + 1) mod N_REQ, go IDLE.
- Latency: req sampled at edge k -> gnt high in cycle k+1 -> rsp_valid high from cycle k+2. If rsp_ready is held high, the next grant comes 3 cycles after the previous one.
- rsp_ready is ignored outside RESP.
- Requests arriving in EXEC/RESP are not sampled; they wait for IDLE.
- A requester must deassert req (or present a new op) in the cycle after its gnt. A req still high in the next IDLE is treated as a new request.
- Fairness: with all requesters continuously requesting, grants cycle 0, 1, ..., N_REQ-1, 0, ...
- A single active requester is granted every transaction regardless of rr_ptr.
- rr_ptr wrap: id = N_REQ-1 -> rr_ptr = 0.
- Operand changes after the grant do not affect the result, because operands are latched.

Decomposition:
- Package gate_arb_pkg holds:
  - Opcode constants OP_NAND = 2'b00, OP_NOR = 2'b01, OP_NOT = 2'b10, OP_ILL = 2'b11.
  - The state enum (IDLE, EXEC, RESP).
- Sub-module gate_unit: purely combinational, inputs op, a, b, outputs y and err. This is the shared datapath, instantiated once.
- The round-robin priority search stays inline as a function.

Test Plan (N_REQ = 4, WIDTH = 8 unless noted):
- Reset mid-RESP: assert rst_n = 0 while rsp_valid = 1 -> all outputs 0 immediately (asynchronously). After release, a req[2] is granted first, proving rr_ptr = 0 and state = IDLE.
- Single request: req = 0001, op0 = NAND, a0 = 0xF0, b0 = 0xCC, rsp_ready = 1 -> gnt = 0001 one cycle after sample; rsp_valid next cycle with rsp_data = 0x3F, rsp_id = 0, rsp_err = 0.
- All opcodes on requester 3, a = 0xA5, b = 0x0F:
  - NOR -> 0x50.
  - NOT -> 0x5A, b ignored.
  - op = 11 -> rsp_data = 0x00, rsp_err = 1.
- Round-robin: req = 1111 held (each requester re-requests after its grant), rsp_ready = 1 -> grant order 0, 1, 2, 3, 0; grants spaced 3 cycles apart.
- Backpressure: rsp_ready = 0 for 5 cycles in RESP, with req[1] asserted and operands changed -> rsp_valid and rsp_data stable, no gnt. After rsp_ready = 1, the next grant goes to requester 1.
- Wrap and skip: last id = 3, req = 0101 -> grant 0. Next grant 2 (requester 1 skipped because idle).
